// File: rtl/rv32i_hart_core.sv
// Single-cycle RV32I core: every rising edge fetches, decodes, executes and retires
// one instruction. Instruction memory, register file and data memory are internal.
module rv32i_hart_core #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input logic clk,
  input logic reset_n
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  logic [31:0] pc_reg, pc_next, pc_plus4, instr;
  logic [31:0] rs1_val, rs2_val, rd_wdata;
  logic        rd_we;

  // Named scopes keep the memory and register array at stable hierarchical paths
  // so program images can be preloaded and results inspected from outside.
  if (1) begin : instruction_mem
    logic [31:0] mem [0:IMEM_WORDS-1];
    assign instr = mem[IAW'(pc_reg >> 2)];
  end

  wire [6:0] opcode = instr[6:0];
  wire [4:0] rd     = instr[11:7];
  wire [2:0] funct3 = instr[14:12];
  wire [4:0] rs1    = instr[19:15];
  wire [4:0] rs2    = instr[24:20];

  wire [31:0] imm_i = {{20{instr[31]}}, instr[31:20]};
  wire [31:0] imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  wire [31:0] imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  wire [31:0] imm_u = {instr[31:12], 12'd0};
  wire [31:0] imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  if (1) begin : i_reg_file
    logic [31:0] reg_file1 [0:31];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) reg_file1[i] <= '0;
      end else if (rd_we && rd != 5'd0) begin
        reg_file1[rd] <= rd_wdata;
      end
    end
    assign rs1_val = reg_file1[rs1];
    assign rs2_val = reg_file1[rs2];
  end

  // ALU shared by OP and OP-IMM; instr[30] means SUB only for register ops.
  wire        is_op = (opcode == OP_OP);
  wire [31:0] alu_b = is_op ? rs2_val : imm_i;
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'd0: alu_res = (is_op && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_res = rs1_val << alu_b[4:0];
      3'd2: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_res = {31'd0, rs1_val < alu_b};
      3'd4: alu_res = rs1_val ^ alu_b;
      3'd5: alu_res = instr[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'd6: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0: br_taken = (rs1_val == rs2_val);
      3'd1: br_taken = (rs1_val != rs2_val);
      3'd4: br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: br_taken = (rs1_val < rs2_val);
      3'd7: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Data memory: only the word index and lane bits of the address matter.
  logic [31:0] dmem_reg [0:DMEM_WORDS-1];
  wire             store_en = (opcode == OP_STORE);
  wire [DAW+1:0]   ls_addr  = (DAW+2)'(rs1_val + (store_en ? imm_s : imm_i));
  wire [DAW-1:0]   dmem_idx = ls_addr[DAW+1:2];
  logic [3:0]      st_be;
  logic [31:0]     st_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_be[gi] = (funct3[1:0] == 2'b10)
                    || (funct3[1:0] == 2'b01 && ls_addr[1] == 1'(gi / 2))
                    || (funct3[1:0] == 2'b00 && ls_addr[1:0] == 2'(gi));
  end

  assign st_data = (funct3[1:0] == 2'b00) ? {4{rs2_val[7:0]}} :
                   (funct3[1:0] == 2'b01) ? {2{rs2_val[15:0]}} : rs2_val;

  always_ff @(posedge clk) begin
    if (reset_n && store_en) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem_reg[dmem_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  wire [31:0] ld_word = dmem_reg[dmem_idx];
  wire [7:0]  ld_byte = ld_word[{ls_addr[1:0], 3'b000} +: 8];
  wire [15:0] ld_half = ls_addr[1] ? ld_word[31:16] : ld_word[15:0];
  logic [31:0] ld_val;
  always_comb begin
    case (funct3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'd0, ld_byte};
      3'd5:    ld_val = {16'd0, ld_half};
      default: ld_val = ld_word;
    endcase
  end

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = alu_res;
    pc_next  = pc_plus4;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_reg + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_next = pc_reg + imm_j; end
      OP_JALR:  begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (br_taken) pc_next = pc_reg + imm_b;
      OP_LOAD:  begin rd_we = 1'b1; rd_wdata = ld_val; end
      OP_IMM, OP_OP: rd_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_reg <= '0;
    else          pc_reg <= pc_next;
  end
endmodule

// File: tb/tb_rv32i_hart_core.sv
// Bench for rv32i_hart_core: a directed program checked each cycle against an
// instruction-level model, plus hand-computed literal expectations.
module tb_rv32i_hart_core;
  localparam int IMEM_WORDS = 1024;
  localparam int DMEM_WORDS = 1024;
  localparam int MBYTES     = 4 * DMEM_WORDS;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  rv32i_hart_core #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .reset_n(reset_n)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [0:IMEM_WORDS-1];
  logic [31:0] m_pc;
  logic [31:0] m_x [0:31];
  logic [7:0]  m_mem [0:MBYTES-1];

  function automatic logic [31:0] rf(input int i);
    return dut.i_reg_file.reg_file1[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic load_prog();
    logic [31:0] p [$];
    p.push_back(enc_i(-1, 0, 0, 1, 'h13));          // 00 addi x1,x0,-1
    p.push_back(enc_i(28, 1, 5, 2, 'h13));          // 04 srli x2,x1,28
    p.push_back(enc_i('h41C, 1, 5, 3, 'h13));       // 08 srai x3,x1,28
    p.push_back(enc_r(0, 1, 0, 3, 4));              // 0C sltu x4,x0,x1
    p.push_back(enc_r('h20, 1, 0, 0, 5));           // 10 sub x5,x0,x1
    p.push_back(enc_u('h12345, 6, 'h37));           // 14 lui x6,0x12345
    p.push_back(enc_i(7, 0, 0, 0, 'h13));           // 18 addi x0,x0,7
    p.push_back(enc_i('h41, 0, 0, 7, 'h13));        // 1C addi x7,x0,0x41
    p.push_back(enc_j(8, 1));                       // 20 jal x1,+8
    p.push_back(enc_i(1, 0, 0, 8, 'h13));           // 24 skipped
    p.push_back(enc_i(0, 7, 0, 9, 'h67));           // 28 jalr x9,0(x7)
    for (int k = 0; k < 5; k++) p.push_back(enc_i(2, 0, 0, 8, 'h13)); // 2C..3C skipped
    p.push_back(enc_i('h100, 0, 0, 11, 'h13));      // 40 addi x11,x0,0x100
    p.push_back(enc_s(0, 0, 11, 2));                // 44 sw x0,0(x11)
    p.push_back(enc_i('h80, 0, 0, 12, 'h13));       // 48 addi x12,x0,0x80
    p.push_back(enc_s(1, 12, 11, 0));               // 4C sb x12,1(x11)
    p.push_back(enc_i(1, 11, 0, 13, 'h03));         // 50 lb x13,1(x11)
    p.push_back(enc_i(1, 11, 4, 14, 'h03));         // 54 lbu x14,1(x11)
    p.push_back(enc_i(0, 11, 2, 15, 'h03));         // 58 lw x15,0(x11)
    p.push_back(enc_u('hC, 16, 'h37));              // 5C lui x16,0xC
    p.push_back(enc_i(-'h111, 16, 0, 16, 'h13));    // 60 addi x16,x16,-0x111
    p.push_back(enc_s(2, 16, 11, 1));               // 64 sh x16,2(x11)
    p.push_back(enc_i(0, 11, 2, 18, 'h03));         // 68 lw x18,0(x11)
    p.push_back(enc_i(2, 11, 1, 19, 'h03));         // 6C lh x19,2(x11)
    p.push_back(enc_i(2, 11, 5, 20, 'h03));         // 70 lhu x20,2(x11)
    p.push_back(enc_i(0, 0, 0, 21, 'h13));          // 74 addi x21,x0,0
    p.push_back(enc_i(5, 0, 0, 22, 'h13));          // 78 addi x22,x0,5
    p.push_back(enc_i(1, 21, 0, 21, 'h13));         // 7C addi x21,x21,1
    p.push_back(enc_b(-4, 22, 21, 1));              // 80 bne x21,x22,-4
    p.push_back(enc_r(0, 0, 3, 2, 23));             // 84 slt x23,x3,x0
    p.push_back(enc_i('hFF, 2, 4, 24, 'h13));       // 88 xori x24,x2,0xFF
    p.push_back(enc_i(-1, 2, 3, 25, 'h13));         // 8C sltiu x25,x2,-1
    p.push_back(enc_u(1, 26, 'h17));                // 90 auipc x26,1
    p.push_back(enc_b(8, 0, 3, 4));                 // 94 blt x3,x0,+8
    p.push_back(enc_i(3, 0, 0, 8, 'h13));           // 98 skipped
    p.push_back(enc_b(8, 0, 3, 7));                 // 9C bgeu x3,x0,+8
    p.push_back(enc_i(4, 0, 0, 8, 'h13));           // A0 skipped
    p.push_back(enc_r(0, 2, 4, 1, 27));             // A4 sll x27,x4,x2
    p.push_back(enc_r('h20, 2, 6, 5, 28));          // A8 sra x28,x6,x2
    p.push_back(enc_r(0, 2, 24, 6, 29));            // AC or x29,x24,x2
    p.push_back(enc_i(7, 1, 7, 30, 'h13));          // B0 andi x30,x1,7
    p.push_back(enc_i(0, 0, 0, 10, 'h13));          // B4 addi x10,x0,0
    p.push_back(enc_i('h5D, 0, 0, 17, 'h13));       // B8 addi x17,x0,0x5D
    p.push_back(enc_b(0, 0, 0, 0));                 // BC beq x0,x0,0
    for (int k = 0; k < IMEM_WORDS; k++) begin
      prog[k] = (k < p.size()) ? p[k] : 32'h0000_0013;
      dut.instruction_mem.mem[k] = prog[k];
    end
    for (int k = 0; k < MBYTES; k++) m_mem[k] = 8'h00;
  endtask

  // Instruction-level reference model
  function automatic logic [7:0] mb(input logic [31:0] a);
    return m_mem[a % MBYTES];
  endfunction

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, y, ii, is, ib, iu, ij, nxt, val, ea;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, t;
    ins = prog[(m_pc >> 2) % IMEM_WORDS];
    a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
    rd = ins[11:7]; f3 = ins[14:12];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 4; wr = 1'b0; val = 32'd0; t = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1; val = iu; end
      7'h17: begin wr = 1; val = m_pc + iu; end
      7'h6f: begin wr = 1; val = m_pc + 4; nxt = m_pc + ij; end
      7'h67: begin wr = 1; val = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = m_pc + ib;
      end
      7'h03: begin
        ea = a + ii; wr = 1;
        case (f3)
          3'd0: val = {{24{mb(ea)[7]}}, mb(ea)};
          3'd4: val = {24'd0, mb(ea)};
          3'd1: begin ea = ea & ~32'd1; val = {{16{mb(ea + 1)[7]}}, mb(ea + 1), mb(ea)}; end
          3'd5: begin ea = ea & ~32'd1; val = {16'd0, mb(ea + 1), mb(ea)}; end
          default: begin ea = ea & ~32'd3; val = {mb(ea + 3), mb(ea + 2), mb(ea + 1), mb(ea)}; end
        endcase
      end
      7'h23: begin
        ea = a + is;
        case (f3)
          3'd0: m_mem[ea % MBYTES] = b[7:0];
          3'd1: begin ea = ea & ~32'd1; for (int k = 0; k < 2; k++) m_mem[(ea + k) % MBYTES] = b[8*k +: 8]; end
          3'd2: begin ea = ea & ~32'd3; for (int k = 0; k < 4; k++) m_mem[(ea + k) % MBYTES] = b[8*k +: 8]; end
          default: ;
        endcase
      end
      7'h13, 7'h33: begin
        wr = 1;
        y = (ins[6:0] == 7'h33) ? b : ii;
        case (f3)
          3'd0: val = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
          3'd1: val = a << y[4:0];
          3'd2: val = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: val = (a < y) ? 32'd1 : 32'd0;
          3'd4: val = a ^ y;
          3'd5: val = ins[30] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
          3'd6: val = a | y;
          default: val = a & y;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = val;
    m_pc = nxt;
  endtask

  always @(posedge clk) if (reset_n) model_step();
  always @(negedge reset_n) model_reset();

  task automatic compare_state();
    int bad = -1;
    check("pc", dut.pc_reg, m_pc);
    for (int i = 0; i < 32; i++) if (bad < 0 && rf(i) !== m_x[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL regfile x%0d: got %08h expected %08h", bad, rf(bad), m_x[bad]);
    end
  endtask

  always @(negedge clk) if (chk_en) compare_state();

  task automatic check_cleared(input string tag);
    check({tag, "_pc"}, dut.pc_reg, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), rf(i), 32'd0);
  endtask

  task automatic check_final();
    check("x0_hardwired", rf(0), 32'h0);
    check("addi_m1",      rf(1) === 32'h24 ? rf(3) : 32'h0, 32'hFFFF_FFFF);
    check("jal_link",     rf(1), 32'h24);
    check("srli",         rf(2), 32'hF);
    check("srai",         rf(3), 32'hFFFF_FFFF);
    check("sltu",         rf(4), 32'h1);
    check("sub",          rf(5), 32'h1);
    check("lui",          rf(6), 32'h1234_5000);
    check("skips",        rf(8), 32'h0);
    check("jalr_link",    rf(9), 32'h2C);
    check("lb",           rf(13), 32'hFFFF_FF80);
    check("lbu",          rf(14), 32'h80);
    check("lw_after_sb",  rf(15), 32'h0000_8000);
    check("lw_after_sh",  rf(18), 32'hBEEF_8000);
    check("lh",           rf(19), 32'hFFFF_BEEF);
    check("lhu",          rf(20), 32'h0000_BEEF);
    check("bne_loop",     rf(21), 32'h5);
    check("slt",          rf(23), 32'h1);
    check("xori",         rf(24), 32'hF0);
    check("sltiu",        rf(25), 32'h1);
    check("auipc",        rf(26), 32'h1090);
    check("sll",          rf(27), 32'h8000);
    check("sra",          rf(28), 32'h2468);
    check("or",           rf(29), 32'hFF);
    check("andi",         rf(30), 32'h4);
    check("x10_pass",     rf(10), 32'h0);
    check("x17_exit",     rf(17), 32'h5D);
    check("spin_pc",      dut.pc_reg, 32'hBC);
  endtask

  task automatic run_to_exit(input string tag);
    time t0 = $time;
    int c;
    for (c = 0; c < 100; c++) begin
      if (rf(17) == 32'h5D) break;
      @(posedge clk); #1;
    end
    check({tag, "_exit_x17"}, rf(17), 32'h5D);
    check({tag, "_exit_in_time"}, (($time - t0) <= 1000) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, "_spin_hold"}, dut.pc_reg, 32'hBC);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check_cleared(tag);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    load_prog();
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_cleared("reset");
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_pc", dut.pc_reg, 32'h4);
    check("first_x1", rf(1), 32'hFFFF_FFFF);
    run_to_exit("run1");
    check_final();
    reset_pulse("rst_spin");
    repeat (25) @(posedge clk);
    reset_pulse("rst_mid");
    run_to_exit("run2");
    check_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
